// File: rtl/pwm_fade_controller.sv
// rtl/pwm_fade_controller.sv - duty-cycle fade ramp with prescaled updates, abort and enable gating
module pwm_fade_controller #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_target,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   diff_d;
    logic [WIDTH-1:0] upd_d;

    // One extra bit on both sides so the clamp sees overflow/underflow instead of a wrap.
    always_comb begin
        sum_d  = {1'b0, duty_q} + {1'b0, step_q};
        diff_d = {1'b0, duty_q} - {1'b0, step_q};
        upd_d  = duty_q;
        if (target_q > duty_q) begin
            upd_d = (sum_d >= {1'b0, target_q}) ? target_q : sum_d[WIDTH-1:0];
        end else begin
            upd_d = (diff_d[WIDTH] || (diff_d[WIDTH-1:0] <= target_q)) ? target_q : diff_d[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= RESET_DUTY;
            target_q <= '0;
            step_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        target_q <= cfg_target;
                        step_q   <= (cfg_step == '0) ? ONE : cfg_step;
                        period_q <= cfg_period;
                        cnt_q    <= cfg_period;
                        ready_q  <= 1'b0;
                        if (cfg_target == duty_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RAMP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (enable) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - ONE;
                        end else begin
                            duty_q <= upd_d;
                            cnt_q  <= period_q;
                            if (upd_d == target_q) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign duty_out  = duty_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// tb/tb_pwm_fade_controller.sv - directed and randomized fades checked against an arithmetic fade model
module tb_pwm_fade_controller;

    localparam int               WIDTH      = 8;
    localparam logic [WIDTH-1:0] RESET_DUTY = 8'h00;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_target;
    logic [WIDTH-1:0] cfg_step;
    logic [WIDTH-1:0] cfg_period;
    logic             enable;
    logic             abort;
    logic [WIDTH-1:0] duty_out;
    logic             busy;
    logic             done;

    int n_chk = 0;
    int n_err = 0;
    int m_duty;

    pwm_fade_controller #(.WIDTH(WIDTH), .RESET_DUTY(RESET_DUTY)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_target (cfg_target),
        .cfg_step   (cfg_step),
        .cfg_period (cfg_period),
        .enable     (enable),
        .abort      (abort),
        .duty_out   (duty_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected duty comes from counting enabled edges since accept: every (P+1)th one moves
    // duty by the step, clamped at the target.
    task automatic fade(input int tgt, input int stp, input int per, input int en_pct,
                        input int hold_from, input int kill_at, input bit kill_rst);
        int s;
        int n;
        bit en;
        bit ab;
        bit rs;
        s = (stp == 0) ? 1 : stp;
        cfg_valid  = 1'b1;
        cfg_target = WIDTH'(tgt);
        cfg_step   = WIDTH'(stp);
        cfg_period = WIDTH'(per);
        enable     = 1'b1;
        abort      = 1'b0;
        tick();
        cfg_valid = 1'b0;
        if (tgt == m_duty) begin
            chk("null_done", 32'(done), 32'd1);
            chk("null_busy", 32'(busy), 32'd0);
            chk("null_duty", 32'(duty_out), 32'(m_duty));
            tick();
            chk("null_idle_ready", 32'(cfg_ready), 32'd1);
            chk("null_done_clr", 32'(done), 32'd0);
            return;
        end
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_ready", 32'(cfg_ready), 32'd0);
        chk("acc_duty", 32'(duty_out), 32'(m_duty));
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_from >= 0 && i >= hold_from && i < hold_from + 5) en = 1'b0;
            else en = ($urandom_range(99) < en_pct);
            ab = (i == kill_at) && !kill_rst;
            rs = (i == kill_at) && kill_rst;
            enable     = en;
            abort      = ab;
            rst        = rs;
            cfg_valid  = ($urandom_range(3) == 0);
            cfg_target = WIDTH'($urandom);
            cfg_step   = WIDTH'($urandom);
            cfg_period = WIDTH'($urandom);
            tick();
            cfg_valid = 1'b0;
            abort     = 1'b0;
            rst       = 1'b0;
            enable    = 1'b1;
            if (rs) begin
                m_duty = int'(RESET_DUTY);
                chk("rst_duty", 32'(duty_out), 32'(m_duty));
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(cfg_ready), 32'd1);
                chk("rst_done", 32'(done), 32'd0);
                return;
            end
            if (ab) begin
                chk("abort_duty", 32'(duty_out), 32'(m_duty));
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(cfg_ready), 32'd1);
                chk("abort_done", 32'(done), 32'd0);
                return;
            end
            if (en) begin
                n++;
                if (n % (per + 1) == 0) begin
                    if (tgt > m_duty) m_duty = (m_duty + s > tgt) ? tgt : m_duty + s;
                    else              m_duty = (m_duty - s < tgt) ? tgt : m_duty - s;
                end
            end
            if (m_duty == tgt) begin
                chk("end_done", 32'(done), 32'd1);
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_duty", 32'(duty_out), 32'(m_duty));
                tick();
                chk("post_done", 32'(done), 32'd0);
                chk("post_ready", 32'(cfg_ready), 32'd1);
                chk("post_duty", 32'(duty_out), 32'(m_duty));
                return;
            end
            chk("ramp_duty", 32'(duty_out), 32'(m_duty));
            chk("ramp_busy", 32'(busy), 32'd1);
            chk("ramp_done", 32'(done), 32'd0);
        end
        chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_target = '0;
        cfg_step   = '0;
        cfg_period = '0;
        enable     = 1'b0;
        abort      = 1'b0;
        tick();
        m_duty = int'(RESET_DUTY);
        chk("reset_duty", 32'(duty_out), 32'(RESET_DUTY));
        chk("reset_ready", 32'(cfg_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        fade(8'h10, 4, 2, 100, -1, -1, 1'b0);
        chk("upfade_final", 32'(duty_out), 32'h10);
        fade(8'hFA, 8'hFF, 0, 100, -1, -1, 1'b0);
        fade(8'hFF, 8'h10, 0, 100, -1, -1, 1'b0);
        chk("sat_final", 32'(duty_out), 32'hFF);
        fade(8'h03, 8'hFF, 0, 100, -1, -1, 1'b0);
        fade(8'h00, 0, 0, 100, -1, -1, 1'b0);
        chk("down_final", 32'(duty_out), 32'h00);
        fade(8'h20, 8, 1, 100, 2, 12, 1'b0);
        chk("abort_hold", 32'(duty_out), 32'h18);
        fade(8'h18, 3, 2, 100, -1, -1, 1'b0);
        fade(8'h40, 8, 0, 100, -1, 1, 1'b1);
        fade(8'h05, 1, 0, 100, -1, -1, 1'b0);
        chk("post_rst_final", 32'(duty_out), 32'h05);

        for (int k = 0; k < 12; k++) begin
            int kill;
            bit krst;
            kill = ($urandom_range(3) == 0) ? int'($urandom_range(30)) : -1;
            krst = ($urandom_range(4) == 0);
            fade(int'($urandom_range(255)),
                 ($urandom_range(7) == 0) ? 255 : int'($urandom_range(40)),
                 int'($urandom_range(3)), 70, -1, kill, krst);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
